// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// Holds the FSM encoding, the instruction width and the error-response word.
package imem_pkg;

    localparam int INSTR_W = 32;

    // addi x0, x0, 0 -- returned whenever a fetch is rejected
    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/imem_array.sv
// DEPTH x WIDTH instruction store: one write port, one registered read port.
// A read and write to the same word on the same edge returns the written data.
module imem_array #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // NOTE: the storage array has no reset branch; resetting it would turn the
    // RAM into a huge bank of flops and would wipe a program loaded before reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register only loads on i_re, so a held word survives later writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_responder.sv
// Responder end of the instruction-fetch interface: one outstanding request,
// WAIT_CYC wait states, registered response held until the fetch stage takes it.
module imem_responder
    import imem_pkg::*;
#(
    parameter int                 DEPTH    = 256,
    parameter int                 WAIT_CYC = 2,
    parameter logic [INSTR_W-1:0] NOP_WORD = imem_pkg::NOP_WORD
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_valid,
    input  logic [31:0]        req_addr,
    output logic               req_ready,
    output logic               rsp_valid,
    output logic [INSTR_W-1:0] rsp_data,
    output logic               rsp_err,
    input  logic               rsp_ready,
    input  logic               ld_we,
    input  logic [31:0]        ld_addr,
    input  logic [INSTR_W-1:0] ld_data
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYC - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nxt;
    logic [31:0]        r_addr;
    logic               r_err;
    logic [31:0]        w_cur_addr;
    logic               w_accept;
    logic               w_enter_resp;
    logic               w_addr_err;
    logic               w_ld_in_range;
    logic [INSTR_W-1:0] w_rd_data;
    logic               w_unused;

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign w_accept  = req_valid & req_ready;

    // With no wait states the read happens on the acceptance edge itself,
    // before r_addr has captured the request, so read straight from the port.
    assign w_cur_addr = (r_state == IDLE) ? req_addr : r_addr;

    // Misalignment has priority, but both produce the same error response.
    assign w_addr_err    = (w_cur_addr[1:0] != 2'b00) || (w_cur_addr[31:IDX_W+2] != '0);
    assign w_ld_in_range = (ld_addr[31:IDX_W+2] == '0);
    assign w_unused      = ^ld_addr[1:0];

    // NOTE: every signal of this block gets a default before the case, so no
    // path leaves one unassigned and no latch can be inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_enter_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYC == 0) begin
                        w_state_nxt  = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt  = RESP;
                    w_enter_resp = 1'b1;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of the order the blocks are evaluated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_addr <= req_addr;
            end
            if (w_enter_resp) begin
                r_err <= w_addr_err;
            end
        end
    end

    imem_array #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (ld_we & w_ld_in_range),
        .i_waddr (ld_addr[IDX_W+1:2]),
        .i_wdata (ld_data),
        .i_re    (w_enter_resp),
        .i_raddr (w_cur_addr[IDX_W+1:2]),
        .o_rdata (w_rd_data)
    );

    // Both terms are registered, so the response is stable while held in RESP.
    assign rsp_data = r_err ? NOP_WORD : w_rd_data;
    assign rsp_err  = r_err;

endmodule
